daq_stream_merge: RTL and testbench

Merges the two 64-bit AXI4-Stream count streams produced by the DAQ block into one tagged AXI4-Stream for a single DMA channel. The m00 (counter-0) stream feeds s00 and the m01 (counter-1) stream feeds s01. Each input is buffered in its own FIFO. A round-robin arbiter forwards words one at a time through a registered output stage. The output is framed into packets of C_PACKET_LEN beats using TLAST.

---
 rtl/daq_stream_merge.sv | 143 ++++++++++++++
 tb/tb_daq_stream_merge.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/daq_stream_merge.sv
// Merges two AXI4-Stream count streams into one tagged stream: per-channel FIFOs,
// round-robin arbitration into a registered output stage, TLAST framing every C_PACKET_LEN beats.
module daq_stream_merge #(
    parameter int C_AXIS_TDATA_WIDTH = 64,
    parameter int C_FIFO_DEPTH       = 16,
    parameter int C_PACKET_LEN       = 32
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic                                s00_axis_tvalid,
    output logic                                s00_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]       s00_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0]     s00_axis_tstrb,
    input  logic                                s00_axis_tlast,
    input  logic                                s01_axis_tvalid,
    output logic                                s01_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]       s01_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0]     s01_axis_tstrb,
    input  logic                                s01_axis_tlast,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0]     m_axis_tstrb,
    output logic                                m_axis_tlast,
    output logic                                m_axis_tuser,
    output logic                                O_FULL_0,
    output logic                                O_FULL_1,
    output logic [$clog2(C_FIFO_DEPTH):0]       O_LEVEL_0,
    output logic [$clog2(C_FIFO_DEPTH):0]       O_LEVEL_1
);

    localparam int SW = C_AXIS_TDATA_WIDTH / 8;
    localparam int EW = C_AXIS_TDATA_WIDTH + SW + 1;
    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = (C_PACKET_LEN > 1) ? $clog2(C_PACKET_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(C_PACKET_LEN - 1);
    localparam logic [LW-1:0] DEPTH_L   = LW'(C_FIFO_DEPTH);

    logic [EW-1:0] r_mem0 [C_FIFO_DEPTH];
    logic [EW-1:0] r_mem1 [C_FIFO_DEPTH];
    logic [LW-1:0] r_wptr0, r_rptr0, r_wptr1, r_rptr1;
    logic          r_in_rdy;

    logic                          r_valid;
    logic [C_AXIS_TDATA_WIDTH-1:0] r_tdata;
    logic [SW-1:0]                 r_tstrb;
    logic                          r_tlast_in;
    logic                          r_chan;
    logic                          r_last_grant;
    logic [BW-1:0]                 r_beat_cnt;

    logic [LW-1:0] w_lvl0, w_lvl1;
    logic          w_full0, w_full1, w_ne0, w_ne1;
    logic          w_wr0, w_wr1, w_load, w_grant, w_pop0, w_pop1, w_fire, w_tlast;
    logic [EW-1:0] w_head;

    // Pointers carry one extra bit so the difference distinguishes full from empty.
    assign w_lvl0  = r_wptr0 - r_rptr0;
    assign w_lvl1  = r_wptr1 - r_rptr1;
    assign w_full0 = (w_lvl0 == DEPTH_L);
    assign w_full1 = (w_lvl1 == DEPTH_L);
    assign w_ne0   = (w_lvl0 != '0);
    assign w_ne1   = (w_lvl1 != '0);

    assign s00_axis_tready = r_in_rdy && !w_full0;
    assign s01_axis_tready = r_in_rdy && !w_full1;
    assign w_wr0 = s00_axis_tvalid && s00_axis_tready;
    assign w_wr1 = s01_axis_tvalid && s01_axis_tready;

    always_comb begin
        w_grant = 1'b0;
        if (w_ne0 && w_ne1) begin
            w_grant = !r_last_grant;
        end else begin
            w_grant = !w_ne0;
        end
    end

    assign w_load = (!r_valid || m_axis_tready) && (w_ne0 || w_ne1);
    assign w_pop0 = w_load && !w_grant;
    assign w_pop1 = w_load && w_grant;
    assign w_head = w_grant ? r_mem1[r_rptr1[AW-1:0]] : r_mem0[r_rptr0[AW-1:0]];
    assign w_fire = r_valid && m_axis_tready;
    assign w_tlast = (r_beat_cnt == LAST_BEAT) || r_tlast_in;

    always_ff @(posedge aclk) begin
        if (w_wr0) r_mem0[r_wptr0[AW-1:0]] <= {s00_axis_tdata, s00_axis_tstrb, s00_axis_tlast};
        if (w_wr1) r_mem1[r_wptr1[AW-1:0]] <= {s01_axis_tdata, s01_axis_tstrb, s01_axis_tlast};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_in_rdy <= 1'b0;
            r_wptr0  <= '0;
            r_rptr0  <= '0;
            r_wptr1  <= '0;
            r_rptr1  <= '0;
        end else begin
            r_in_rdy <= 1'b1;
            if (w_wr0)  r_wptr0 <= r_wptr0 + LW'(1);
            if (w_wr1)  r_wptr1 <= r_wptr1 + LW'(1);
            if (w_pop0) r_rptr0 <= r_rptr0 + LW'(1);
            if (w_pop1) r_rptr1 <= r_rptr1 + LW'(1);
        end
    end

    // Output stage: a held word stays put until accepted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_valid      <= 1'b0;
            r_tdata      <= '0;
            r_tstrb      <= '0;
            r_tlast_in   <= 1'b0;
            r_chan       <= 1'b0;
            r_last_grant <= 1'b1;
            r_beat_cnt   <= '0;
        end else begin
            if (w_load) begin
                {r_tdata, r_tstrb, r_tlast_in} <= w_head;
                r_chan       <= w_grant;
                r_last_grant <= w_grant;
                r_valid      <= 1'b1;
            end else if (m_axis_tready) begin
                r_valid <= 1'b0;
            end
            if (w_fire) begin
                r_beat_cnt <= w_tlast ? '0 : r_beat_cnt + BW'(1);
            end
        end
    end

    assign m_axis_tvalid = r_valid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tstrb  = r_tstrb;
    assign m_axis_tlast  = r_valid && w_tlast;
    assign m_axis_tuser  = r_chan;
    assign O_FULL_0      = w_full0;
    assign O_FULL_1      = w_full1;
    assign O_LEVEL_0     = w_lvl0;
    assign O_LEVEL_1     = w_lvl1;

endmodule

// File: tb/tb_daq_stream_merge.sv
// Bench for daq_stream_merge: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_daq_stream_merge;

    localparam int W  = 64;
    localparam int S  = W / 8;
    localparam int D  = 16;
    localparam int PL = 4;
    localparam int LW = $clog2(D) + 1;

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic         s00_tvalid = 1'b0, s01_tvalid = 1'b0;
    logic         s00_tready, s01_tready;
    logic [W-1:0] s00_tdata = '0, s01_tdata = '0;
    logic [S-1:0] s00_tstrb = '0, s01_tstrb = '0;
    logic         s00_tlast = 1'b0, s01_tlast = 1'b0;
    logic         m_tvalid, m_tlast, m_tuser;
    logic         m_tready = 1'b0;
    logic [W-1:0] m_tdata;
    logic [S-1:0] m_tstrb;
    logic         full0, full1;
    logic [LW-1:0] lvl0, lvl1;

    daq_stream_merge #(.C_AXIS_TDATA_WIDTH(W), .C_FIFO_DEPTH(D), .C_PACKET_LEN(PL)) dut (
        .aclk(clk), .aresetn(aresetn),
        .s00_axis_tvalid(s00_tvalid), .s00_axis_tready(s00_tready), .s00_axis_tdata(s00_tdata),
        .s00_axis_tstrb(s00_tstrb), .s00_axis_tlast(s00_tlast),
        .s01_axis_tvalid(s01_tvalid), .s01_axis_tready(s01_tready), .s01_axis_tdata(s01_tdata),
        .s01_axis_tstrb(s01_tstrb), .s01_axis_tlast(s01_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_tstrb(m_tstrb), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .O_FULL_0(full0), .O_FULL_1(full1), .O_LEVEL_0(lvl0), .O_LEVEL_1(lvl1)
    );

    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] d; logic [S-1:0] s; logic l; } ent_t;
    typedef struct { logic [W-1:0] d; logic u; logic l; int c; } log_t;

    // Reference model state
    ent_t q0[$], q1[$];
    bit   mv, m_tl, m_user, m_lg, m_rdy, m_acc0, m_acc1;
    logic [W-1:0] m_d;
    logic [S-1:0] m_s;
    int   m_cnt;

    log_t dut_log[$];
    int   checks = 0, errors = 0, cyc = 0;
    bit   chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete();
        mv = 0; m_tl = 0; m_user = 0; m_lg = 1; m_rdy = 0; m_cnt = 0;
        m_d = '0; m_s = '0; m_acc0 = 0; m_acc1 = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit a0, a1, fire, load, g;
        ent_t e;
        m_acc0 = 0; m_acc1 = 0;
        if (!aresetn) return;
        a0   = s00_tvalid && m_rdy && (q0.size() < D);
        a1   = s01_tvalid && m_rdy && (q1.size() < D);
        fire = mv && m_tready;
        load = (!mv || m_tready) && (q0.size() > 0 || q1.size() > 0);
        if (fire) begin
            if (m_cnt == PL - 1 || m_tl) m_cnt = 0;
            else m_cnt++;
        end
        if (load) begin
            if (q0.size() > 0 && q1.size() > 0) g = !m_lg;
            else g = (q0.size() == 0);
            if (!g) e = q0.pop_front();
            else    e = q1.pop_front();
            m_d = e.d; m_s = e.s; m_tl = e.l; m_user = g; m_lg = g; mv = 1;
        end else if (fire) begin
            mv = 0;
        end
        if (a0) q0.push_back('{s00_tdata, s00_tstrb, s00_tlast});
        if (a1) q1.push_back('{s01_tdata, s01_tstrb, s01_tlast});
        m_acc0 = a0; m_acc1 = a1;
        m_rdy = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            chk("tvalid", 64'(m_tvalid), 64'(mv));
            if (mv) begin
                chk("tdata", m_tdata, m_d);
                chk("tstrb", 64'(m_tstrb), 64'(m_s));
                chk("tlast", 64'(m_tlast), 64'((m_cnt == PL - 1) || m_tl));
                chk("tuser", 64'(m_tuser), 64'(m_user));
            end
            chk("level0", 64'(lvl0), 64'(q0.size()));
            chk("level1", 64'(lvl1), 64'(q1.size()));
            chk("full0", 64'(full0), 64'(q0.size() == D));
            chk("full1", 64'(full1), 64'(q1.size() == D));
            chk("tready0", 64'(s00_tready), 64'(m_rdy && q0.size() < D));
            chk("tready1", 64'(s01_tready), 64'(m_rdy && q1.size() < D));
            if (m_tvalid && m_tready && aresetn)
                dut_log.push_back('{m_tdata, m_tuser, m_tlast, cyc});
        end
    end

    task automatic idle_inputs();
        s00_tvalid = 0; s01_tvalid = 0; s00_tlast = 0; s01_tlast = 0;
        s00_tstrb = '1; s01_tstrb = '1;
    endtask

    task automatic reset_seq();
        idle_inputs();
        aresetn = 0;
        model_reset();
        repeat (5) tick();
        chk_en = 1;
        chk("rst_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_tdata", m_tdata, 64'(0));
        chk("rst_tstrb", 64'(m_tstrb), 64'(0));
        chk("rst_tlast", 64'(m_tlast), 64'(0));
        chk("rst_tuser", 64'(m_tuser), 64'(0));
        chk("rst_tready0", 64'(s00_tready), 64'(0));
        chk("rst_tready1", 64'(s01_tready), 64'(0));
        aresetn = 1;
        tick();
        chk("rel_tready0", 64'(s00_tready), 64'(1));
        chk("rel_tready1", 64'(s01_tready), 64'(1));
        chk("rel_level0", 64'(lvl0), 64'(0));
        chk("rel_level1", 64'(lvl1), 64'(0));
        dut_log.delete();
    endtask

    initial begin
        int n;
        int rb;
        model_reset();

        // Single channel, latency
        reset_seq();
        m_tready = 1;
        s00_tvalid = 1; s00_tdata = 64'd1;
        tick();
        chk("lat_edge_k", 64'(m_tvalid), 64'(0));
        s00_tdata = 64'd2;
        tick();
        chk("lat_edge_k1_valid", 64'(m_tvalid), 64'(1));
        chk("lat_edge_k1_data", m_tdata, 64'd1);
        s00_tdata = 64'd3;
        tick();
        s00_tvalid = 0;
        repeat (4) tick();
        chk("single_count", 64'(dut_log.size()), 64'(3));
        for (int i = 0; i < 3 && i < dut_log.size(); i++) begin
            chk("single_data", dut_log[i].d, 64'(i + 1));
            chk("single_user", 64'(dut_log[i].u), 64'(0));
            chk("single_last", 64'(dut_log[i].l), 64'(0));
        end

        // Contention
        reset_seq();
        m_tready = 1;
        for (int i = 0; i < 12; i++) begin
            s00_tvalid = 1; s00_tdata = 64'h10 + 64'(i);
            s01_tvalid = 1; s01_tdata = 64'h20 + 64'(i);
            tick();
        end
        idle_inputs();
        repeat (30) tick();
        chk("cont_count", 64'(dut_log.size()), 64'(24));
        for (int i = 0; i < 8 && i < dut_log.size(); i++) begin
            chk("cont_user", 64'(dut_log[i].u), 64'(i % 2));
            chk("cont_data", dut_log[i].d, ((i % 2) ? 64'h20 : 64'h10) + 64'(i / 2));
            if (i > 0) chk("cont_rate", 64'(dut_log[i].c - dut_log[i-1].c), 64'(1));
        end

        // Backpressure
        reset_seq();
        m_tready = 0;
        n = 0;
        s00_tvalid = 1; s00_tdata = 64'h100;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (m_acc0) begin
                n++;
                s00_tdata = 64'h100 + 64'(n);
                if (n == 20) s00_tvalid = 0;
            end
        end
        s00_tvalid = 0;
        chk("bp_accepted", 64'(n), 64'(17));
        chk("bp_tready0", 64'(s00_tready), 64'(0));
        chk("bp_full0", 64'(full0), 64'(1));
        chk("bp_level0", 64'(lvl0), 64'(16));
        m_tready = 1;
        repeat (25) tick();
        chk("bp_drain_count", 64'(dut_log.size()), 64'(17));
        for (int i = 0; i < dut_log.size(); i++)
            chk("bp_order", dut_log[i].d, 64'h100 + 64'(i));

        // Framing
        reset_seq();
        m_tready = 1;
        for (int i = 0; i < 14; i++) begin
            s00_tvalid = 1; s00_tdata = 64'h200 + 64'(i); s00_tlast = (i == 9);
            tick();
        end
        idle_inputs();
        repeat (10) tick();
        chk("frame_count", 64'(dut_log.size()), 64'(14));
        for (int i = 0; i < dut_log.size(); i++)
            chk("frame_tlast", 64'(dut_log[i].l), 64'(i == 3 || i == 7 || i == 9 || i == 13));

        // Reset mid-stream
        reset_seq();
        m_tready = 0;
        for (int i = 0; i < 6; i++) begin
            s00_tvalid = 1;       s00_tdata = 64'hA0 + 64'(i);
            s01_tvalid = (i < 5); s01_tdata = 64'hB0 + 64'(i);
            tick();
        end
        idle_inputs();
        tick();
        chk("mid_level0", 64'(lvl0), 64'(5));
        chk("mid_level1", 64'(lvl1), 64'(5));
        chk("mid_valid", 64'(m_tvalid), 64'(1));
        aresetn = 0;
        model_reset();
        #1;
        chk("mid_rst_valid", 64'(m_tvalid), 64'(0));
        chk("mid_rst_data", m_tdata, 64'(0));
        chk("mid_rst_level0", 64'(lvl0), 64'(0));
        chk("mid_rst_level1", 64'(lvl1), 64'(0));
        chk("mid_rst_tready0", 64'(s00_tready), 64'(0));
        repeat (2) tick();
        aresetn = 1;
        tick();
        dut_log.delete();
        m_tready = 1;
        s00_tvalid = 1; s00_tdata = 64'hC0;
        s01_tvalid = 1; s01_tdata = 64'hD0;
        tick();
        idle_inputs();
        repeat (5) tick();
        chk("mid_after_count", 64'(dut_log.size()), 64'(2));
        if (dut_log.size() >= 2) begin
            chk("mid_after_first_user", 64'(dut_log[0].u), 64'(0));
            chk("mid_after_first_data", dut_log[0].d, 64'hC0);
            chk("mid_after_second_user", 64'(dut_log[1].u), 64'(1));
            chk("mid_after_second_data", dut_log[1].d, 64'hD0);
        end

        // Randomized traffic with varying backpressure and one async reset
        reset_seq();
        for (int c = 0; c < 3000; c++) begin
            rb = (c / 250) % 3;
            s00_tvalid = ($urandom_range(0, 3) != 0);
            s01_tvalid = ($urandom_range(0, 2) != 0);
            s00_tdata  = {$urandom, $urandom};
            s01_tdata  = {$urandom, $urandom};
            s00_tstrb  = S'($urandom);
            s01_tstrb  = S'($urandom);
            s00_tlast  = ($urandom_range(0, 7) == 0);
            s01_tlast  = ($urandom_range(0, 7) == 0);
            m_tready   = (rb == 0) ? ($urandom_range(0, 3) == 0) :
                         (rb == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (c == 1500) begin
                aresetn = 0;
                model_reset();
                tick();
                aresetn = 1;
            end
            tick();
        end
        idle_inputs();
        m_tready = 1;
        repeat (40) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
